// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle for pulse_stretcher: tick/len/retrig in, stretched level and event ticks out.
interface pulse_stretcher_if #(parameter int W = 16);
   logic         tick;
   logic [W-1:0] len;
   logic         retrig;
   logic         level;
   logic         done_tick;
   logic         miss_tick;

   modport master (output tick, len, retrig, input level, done_tick, miss_tick);
   modport slave  (input tick, len, retrig, output level, done_tick, miss_tick);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches accepted single-cycle ticks into a len-cycle high level, with optional
// retrigger and a fixed GAP-cycle low hold after every pulse.
module pulse_stretcher #(
   parameter int W   = 16,
   parameter int GAP = 0
) (
   input  logic clk,
   input  logic reset,
   pulse_stretcher_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, STRETCH = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [W-1:0] GAP_M1 = (GAP > 0) ? W'(GAP - 1) : '0;

   state_t       state;
   logic [W-1:0] cnt;
   logic         level_q;
   logic         len_nz;
   logic         take_idle;
   logic         take_retrig;

   assign len_nz      = |bus.len;
   assign take_idle   = (state == IDLE) && bus.tick && len_nz;
   assign take_retrig = (state == STRETCH) && bus.tick && bus.retrig && len_nz;

   // Event ticks are gated by reset so they drop at once, even with tick held high.
   assign bus.done_tick = !reset && (state == STRETCH) && (cnt == '0) && !take_retrig;
   assign bus.miss_tick = !reset && bus.tick && !take_idle && !take_retrig;
   assign bus.level     = level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         level_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take_idle) begin
                  state   <= STRETCH;
                  cnt     <= bus.len - W'(1);
                  level_q <= 1'b1;
               end
            end
            STRETCH: begin
               // Retrigger wins over expiry on the cnt==0 cycle.
               if (take_retrig) begin
                  cnt <= bus.len - W'(1);
               end else if (cnt == '0) begin
                  level_q <= 1'b0;
                  if (GAP > 0) begin
                     state <= HOLD;
                     cnt   <= GAP_M1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - W'(1);
               end
            end
            HOLD: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - W'(1);
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized + directed bench: absolute-time reference model feeds per-cycle expectation
// queues; a negedge monitor pops and compares for a GAP=0 and a GAP=3 instance.
module tb_pulse_stretcher;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pulse_stretcher_if #(.W(W)) if0 ();
   pulse_stretcher_if #(.W(W)) if1 ();

   pulse_stretcher #(.W(W), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   pulse_stretcher #(.W(W), .GAP(3)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [2:0] q0[$];
   logic [2:0] q1[$];
   longint end_hi[2] = '{-1000, -1000};
   int gapv[2] = '{0, 3};

   // Model: a pulse is just "last high cycle" end_hi; busy-high while cyc<=end_hi,
   // ready to accept once cyc is past end_hi+GAP. Outputs are {level, done, miss}.
   task automatic model(input int k, input bit rst_v, input bit tk, input logic [W-1:0] ln,
                        input bit rt, output logic [2:0] e);
      bit busy, idle, take, acc;
      if (rst_v) begin
         end_hi[k] = -1000;
         e = 3'b000;
         return;
      end
      busy = (cyc <= end_hi[k]);
      idle = (cyc > end_hi[k] + gapv[k]);
      take = busy && tk && rt && (ln != 0);
      acc  = idle && tk && (ln != 0);
      e = {busy, busy && (cyc == end_hi[k]) && !take, tk && !take && !acc};
      if (take || acc) end_hi[k] = cyc + longint'(ln);
   endtask

   task automatic step(input bit rst_v, input bit tk, input logic [W-1:0] ln, input bit rt);
      logic [2:0] e;
      @(posedge clk);
      #1;
      cyc++;
      reset = rst_v;
      if0.tick = tk; if0.len = ln; if0.retrig = rt;
      if1.tick = tk; if1.len = ln; if1.retrig = rt;
      model(0, rst_v, tk, ln, rt, e); q0.push_back(e);
      model(1, rst_v, tk, ln, rt, e); q1.push_back(e);
   endtask

   // Idle cycles carry a random len to show it is ignored outside acceptance.
   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, W'($urandom), 1'(($urandom)));
   endtask

   logic [2:0] exp0, exp1;
   always @(negedge clk) begin
      if (q0.size() != 0) begin
         exp0 = q0.pop_front();
         checks++;
         if ({if0.level, if0.done_tick, if0.miss_tick} !== exp0) begin
            errors++;
            $display("FAIL gap0 cyc=%0d got{lvl,done,miss}=%b exp=%b", cyc,
                     {if0.level, if0.done_tick, if0.miss_tick}, exp0);
         end
      end
      if (q1.size() != 0) begin
         exp1 = q1.pop_front();
         checks++;
         if ({if1.level, if1.done_tick, if1.miss_tick} !== exp1) begin
            errors++;
            $display("FAIL gap3 cyc=%0d got{lvl,done,miss}=%b exp=%b", cyc,
                     {if1.level, if1.done_tick, if1.miss_tick}, exp1);
         end
      end
   end

   initial begin
      if0.tick = 1'b0; if0.len = '0; if0.retrig = 1'b0;
      if1.tick = 1'b0; if1.len = '0; if1.retrig = 1'b0;
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      idle(2);

      // basic len=5
      step(1'b0, 1'b1, 8'd5, 1'b0); idle(8);
      // retrigger extends
      step(1'b0, 1'b1, 8'd4, 1'b1); idle(1);
      step(1'b0, 1'b1, 8'd4, 1'b1); idle(8);
      // drops during pulse and gap
      step(1'b0, 1'b1, 8'd4, 1'b0); idle(1);
      step(1'b0, 1'b1, 8'd4, 1'b0); idle(3);
      step(1'b0, 1'b1, 8'd4, 1'b0); idle(1);
      step(1'b0, 1'b1, 8'd4, 1'b0); idle(10);
      // len=0 and len=1
      step(1'b0, 1'b1, 8'd0, 1'b0); idle(2);
      step(1'b0, 1'b1, 8'd1, 1'b0); idle(5);
      // reset mid-pulse with tick held, then restart
      step(1'b0, 1'b1, 8'd10, 1'b0); idle(2);
      step(1'b1, 1'b1, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 8'd10, 1'b0); idle(14);
      // max len, tick on the expiry cycle with and without retrigger
      step(1'b0, 1'b1, 8'd255, 1'b1); idle(254);
      step(1'b0, 1'b1, 8'd255, 1'b1); idle(262);
      step(1'b0, 1'b1, 8'd255, 1'b0); idle(254);
      step(1'b0, 1'b1, 8'd255, 1'b0); idle(10);

      repeat (3000)
         step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 12)),
              1'($urandom_range(0, 1)));
      idle(20);

      @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d/%0d pending exp=0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
